// File: rtl/uart_tx_arbiter_pkg.sv
// uart_tx_arbiter_pkg
// Shared definitions for the UART transmit arbiter slice: the arbiter state
// encoding and the default sizing constants used by the arbiter and its
// round-robin picker.
package uart_tx_arbiter_pkg;

    localparam int DEF_NUM_REQ        = 4;
    localparam int DEF_PAYLOAD_BITS   = 8;
    localparam int DEF_TIMEOUT_CYCLES = 65535;

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_HI,
        WAIT_LO,
        HOLD
    } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick
// Combinational round-robin picker. The search starts at the requester just
// after last_grant and wraps around, so the previous owner has the lowest
// priority.
//   req        : request vector, one bit per requester
//   last_grant : index of the most recently granted requester
//   winner     : one-hot selected requester (all-zero when none requests)
//   any        : high when at least one request is present
module rr_pick
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [NUM_REQ-1:0] winner,
    output logic               any
);

    logic [IDX_W-1:0] idx;

    // Walk offsets 1..NUM_REQ from last_grant; the first requesting slot wins.
    always_comb begin
        winner = '0;
        any    = 1'b0;
        idx    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = IDX_W'((int'(last_grant) + k) % NUM_REQ);
            if (!any && req[idx]) begin
                winner[idx] = 1'b1;
                any         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Shares one UART transmitter between several byte-stream requesters. A
// requester that wins arbitration owns the transmitter until it sends a beat
// flagged last, or until it stays silent for TIMEOUT_CYCLES while owning it.
//   clk, rst   : clock and asynchronous active-high reset
//   req_valid  : per-requester beat valid
//   req_data   : packed beats, requester i at [i*PAYLOAD_BITS +: PAYLOAD_BITS]
//   req_last   : per-requester end-of-message flag
//   req_ready  : one-cycle accept pulse back to the requester
//   tx_data    : byte presented to the UART (held until the next accept)
//   tx_en      : one-cycle start pulse to the UART
//   tx_busy    : UART busy indication
//   grant      : one-hot current owner, zero when unowned
//   timeout    : one-cycle pulse when an idle owner is forcibly released
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ        = DEF_NUM_REQ,
    parameter int PAYLOAD_BITS   = DEF_PAYLOAD_BITS,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ*PAYLOAD_BITS-1:0] req_data,
    input  logic [NUM_REQ-1:0]              req_last,
    output logic [NUM_REQ-1:0]              req_ready,
    output logic [PAYLOAD_BITS-1:0]         tx_data,
    output logic                            tx_en,
    input  logic                            tx_busy,
    output logic [NUM_REQ-1:0]              grant,
    output logic                            timeout
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);

    arb_state_t              state_q, state_d;
    logic [NUM_REQ-1:0]      grant_q, grant_d;
    logic [IDX_W-1:0]        last_grant_q, last_grant_d;
    logic [PAYLOAD_BITS-1:0] data_q, data_d;
    logic                    last_q, last_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;

    logic [NUM_REQ-1:0]      rr_winner;
    logic                    rr_any;
    logic [IDX_W-1:0]        win_idx;
    logic [PAYLOAD_BITS-1:0] beats [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_beats
        assign beats[g] = req_data[g*PAYLOAD_BITS +: PAYLOAD_BITS];
    end

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req        (req_valid),
        .last_grant (last_grant_q),
        .winner     (rr_winner),
        .any        (rr_any)
    );

    // Encode the one-hot winner so it can index the beat array and be stored
    // as the next round-robin starting point.
    always_comb begin
        win_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (rr_winner[i]) begin
                win_idx = IDX_W'(i);
            end
        end
    end

    // Next-state and output decode. req_ready is a combinational accept so
    // the beat is latched on the same edge the requester sees its handshake,
    // giving tx_en exactly one cycle after acceptance.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        data_d       = data_q;
        last_d       = last_q;
        cnt_d        = cnt_q;
        req_ready    = '0;
        tx_en        = 1'b0;
        timeout      = 1'b0;

        case (state_q)
            IDLE: begin
                if (rr_any && !tx_busy) begin
                    req_ready    = rr_winner;
                    grant_d      = rr_winner;
                    last_grant_d = win_idx;
                    data_d       = beats[win_idx];
                    last_d       = req_last[win_idx];
                    state_d      = START;
                end
            end
            START: begin
                tx_en   = 1'b1;
                state_d = WAIT_HI;
            end
            WAIT_HI: begin
                if (tx_busy) begin
                    state_d = WAIT_LO;
                end
            end
            WAIT_LO: begin
                if (!tx_busy) begin
                    if (last_q) begin
                        grant_d = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d   = '0;
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                // Only the owner is listened to; a waiting beat wins over an
                // expiring idle counter.
                if (|(req_valid & grant_q)) begin
                    req_ready = grant_q;
                    data_d    = beats[last_grant_q];
                    last_d    = req_last[last_grant_q];
                    cnt_d     = '0;
                    state_d   = START;
                end else if (cnt_q == TIMEOUT_VAL) begin
                    timeout = 1'b1;
                    grant_d = '0;
                    state_d = IDLE;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // The state already sits in IDLE while reset is held, so only the
        // accept pulse needs masking to keep outputs quiet during reset.
        if (rst) begin
            req_ready = '0;
        end
    end

    // State and datapath registers; last_grant resets to the top index so
    // requester 0 has first priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= IDX_W'(NUM_REQ - 1);
            data_q       <= '0;
            last_q       <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            data_q       <= data_d;
            last_q       <= last_d;
            cnt_q        <= cnt_d;
        end
    end

    assign tx_data = data_q;
    assign grant   = grant_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter
// Directed bench for uart_tx_arbiter with a short idle timeout. Requesters
// are modelled as beat queues, the UART as a busy pulse of programmable
// length started by each tx_en.
module tb_uart_tx_arbiter;

    localparam int NR = 4;
    localparam int PB = 8;
    localparam int TO = 16;

    typedef struct packed {
        logic [PB-1:0] data;
        logic          last;
    } beat_t;

    typedef struct packed {
        logic [PB-1:0] data;
        logic [NR-1:0] gnt;
    } tx_rec_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [NR-1:0]    req_valid = '0;
    logic [NR*PB-1:0] req_data = '0;
    logic [NR-1:0]    req_last = '0;
    logic [NR-1:0]    req_ready;
    logic [PB-1:0]    tx_data;
    logic             tx_en;
    logic             tx_busy = 1'b0;
    logic [NR-1:0]    grant;
    logic             timeout;

    beat_t   req_q [NR][$];
    tx_rec_t tx_log[$];
    logic [NR-1:0] pop_req = '0;

    int cyc = 0;
    int checks = 0;
    int passes = 0;
    int multi_ready = 0;
    int ready_cnt = 0;
    int ready_hits [NR] = '{0, 0, 0, 0};
    int ready1_cyc = 0;
    int tx_cnt = 0;
    int timeout_cnt = 0;
    int timeout_cyc = 0;
    int timeout_lat = 0;
    int last_fall_cyc = 0;
    int busy_len = 3;
    int busy_left = 0;

    uart_tx_arbiter #(
        .NUM_REQ        (NR),
        .PAYLOAD_BITS   (PB),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .tx_data   (tx_data),
        .tx_en     (tx_en),
        .tx_busy   (tx_busy),
        .grant     (grant),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    // Mid-cycle monitor: record handshakes, transmit starts and timeouts,
    // then advance the UART busy model.
    always @(negedge clk) begin
        cyc = cyc + 1;
        pop_req = '0;
        if (!rst) begin
            if ($countones(req_ready) > 1) multi_ready++;
            for (int i = 0; i < NR; i++) begin
                if (req_ready[i]) begin
                    pop_req[i] = 1'b1;
                    ready_hits[i]++;
                    ready_cnt++;
                    if (i == 1) ready1_cyc = cyc;
                end
            end
            if (tx_en) begin
                tx_cnt++;
                tx_log.push_back('{data: tx_data, gnt: grant});
                busy_left = busy_len;
            end
            if (timeout) begin
                timeout_cnt++;
                timeout_cyc = cyc;
                timeout_lat = cyc - last_fall_cyc;
            end
        end else begin
            busy_left = 0;
        end
        if (busy_left > 0) begin
            tx_busy = 1'b1;
            busy_left--;
        end else begin
            if (tx_busy) last_fall_cyc = cyc;
            tx_busy = 1'b0;
        end
    end

    // Requester model: retire beats accepted on the previous edge, then
    // present the head of each queue.
    always @(posedge clk) begin
        #2;
        for (int i = 0; i < NR; i++) begin
            if (pop_req[i] && req_q[i].size() > 0) void'(req_q[i].pop_front());
        end
        for (int i = 0; i < NR; i++) begin
            if (req_q[i].size() > 0) begin
                req_valid[i]         = 1'b1;
                req_data[i*PB +: PB] = req_q[i][0].data;
                req_last[i]          = req_q[i][0].last;
            end else begin
                req_valid[i]         = 1'b0;
                req_data[i*PB +: PB] = '0;
                req_last[i]          = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got running, expected finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    endtask

    task automatic applyStimulus(input int r, input logic [PB-1:0] d, input logic l);
        req_q[r].push_back('{data: d, last: l});
    endtask

    task automatic stepDrive();
        @(posedge clk);
        #1;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) stepDrive();
    endtask

    task automatic waitTx(input string tag, input int n, input int max);
        int k = 0;
        while (tx_log.size() < n && k < max) begin
            stepDrive();
            k++;
        end
        checkOutput(tag, 32'(tx_log.size() >= n), 32'd1);
    endtask

    task automatic waitQuiet(input string tag, input int max);
        int  k = 0;
        bit  quiet = 1'b0;
        while (!quiet && k < max) begin
            stepDrive();
            k++;
            quiet = (req_q[0].size() == 0) && (req_q[1].size() == 0) &&
                    (req_q[2].size() == 0) && (req_q[3].size() == 0) &&
                    !tx_busy && (grant == '0);
        end
        checkOutput(tag, 32'(quiet), 32'd1);
    endtask

    task automatic startTest();
        stepDrive();
        tx_log.delete();
    endtask

    task automatic resetDut();
        stepDrive();
        rst = 1'b1;
        for (int i = 0; i < NR; i++) req_q[i].delete();
        waitCycles(2);
        rst = 1'b0;
    endtask

    function automatic logic [31:0] txData(input int i);
        return (i < tx_log.size()) ? 32'(tx_log[i].data) : 32'hDEAD;
    endfunction

    function automatic logic [31:0] txGrant(input int i);
        return (i < tx_log.size()) ? 32'(tx_log[i].gnt) : 32'hDEAD;
    endfunction

    int snap_tx, snap_ready, snap_r3, snap_to;

    initial begin
        // Reset values while reset is held.
        stepDrive();
        checkOutput("rst_grant",   32'(grant),     32'h0);
        checkOutput("rst_ready",   32'(req_ready), 32'h0);
        checkOutput("rst_tx_en",   32'(tx_en),     32'h0);
        checkOutput("rst_tx_data", 32'(tx_data),   32'h0);
        checkOutput("rst_timeout", 32'(timeout),   32'h0);
        stepDrive();
        rst = 1'b0;

        // Requester 1 sends a two-byte message alone.
        startTest();
        applyStimulus(1, 8'h41, 1'b0);
        applyStimulus(1, 8'h42, 1'b1);
        waitQuiet("A_done", 200);
        checkOutput("A_tx_count", 32'(tx_log.size()), 32'd2);
        checkOutput("A_tx0_data", txData(0),  32'h41);
        checkOutput("A_tx0_gnt",  txGrant(0), 32'h2);
        checkOutput("A_tx1_data", txData(1),  32'h42);
        checkOutput("A_tx1_gnt",  txGrant(1), 32'h2);
        checkOutput("A_gnt_end",  32'(grant), 32'h0);

        // Round-robin order from reset, then with everyone requesting.
        resetDut();
        startTest();
        applyStimulus(0, 8'hA0, 1'b1);
        applyStimulus(2, 8'hC0, 1'b1);
        waitQuiet("B1_done", 200);
        checkOutput("B_tx0_gnt",  txGrant(0), 32'h1);
        checkOutput("B_tx0_data", txData(0),  32'hA0);
        checkOutput("B_tx1_gnt",  txGrant(1), 32'h4);
        checkOutput("B_tx1_data", txData(1),  32'hC0);
        stepDrive();
        applyStimulus(0, 8'hA1, 1'b1);
        applyStimulus(1, 8'hB1, 1'b1);
        applyStimulus(2, 8'hC1, 1'b1);
        applyStimulus(3, 8'hD1, 1'b1);
        waitQuiet("B2_done", 300);
        checkOutput("B_tx2_gnt",  txGrant(2), 32'h8);
        checkOutput("B_tx2_data", txData(2),  32'hD1);
        checkOutput("B_tx3_gnt",  txGrant(3), 32'h1);
        checkOutput("B_tx4_gnt",  txGrant(4), 32'h2);
        checkOutput("B_tx5_gnt",  txGrant(5), 32'h4);
        checkOutput("B_tx5_data", txData(5),  32'hC1);

        // Requester 3 must wait while requester 0 holds the lock.
        startTest();
        applyStimulus(0, 8'h10, 1'b0);
        waitTx("C_first_tx", 1, 50);
        stepDrive();
        snap_r3 = ready_hits[3];
        applyStimulus(3, 8'h30, 1'b1);
        waitCycles(8);
        checkOutput("C_gnt_locked", 32'(grant), 32'h1);
        checkOutput("C_r3_blocked", 32'(ready_hits[3] - snap_r3), 32'd0);
        applyStimulus(0, 8'h11, 1'b1);
        waitQuiet("C_done", 200);
        checkOutput("C_tx1_data", txData(1),  32'h11);
        checkOutput("C_tx1_gnt",  txGrant(1), 32'h1);
        checkOutput("C_tx2_data", txData(2),  32'h30);
        checkOutput("C_tx2_gnt",  txGrant(2), 32'h8);

        // Requester 0 stalls mid-message; the lock times out.
        startTest();
        snap_to = timeout_cnt;
        applyStimulus(0, 8'h20, 1'b0);
        waitTx("D_first_tx", 1, 50);
        stepDrive();
        applyStimulus(1, 8'h50, 1'b1);
        waitQuiet("D_done", 300);
        checkOutput("D_timeouts", 32'(timeout_cnt - snap_to), 32'd1);
        // HOLD is entered the cycle after busy falls, so subtract that cycle.
        checkOutput("D_to_after_hold", 32'(timeout_lat - 1), 32'd16);
        checkOutput("D_r1_accept_lat", 32'(ready1_cyc - timeout_cyc), 32'd1);
        checkOutput("D_tx1_data", txData(1),  32'h50);
        checkOutput("D_tx1_gnt",  txGrant(1), 32'h2);

        // Reset while waiting for the UART to finish.
        startTest();
        busy_len = 40;
        applyStimulus(2, 8'h77, 1'b0);
        waitTx("E_first_tx", 1, 50);
        waitCycles(3);
        rst = 1'b1;
        for (int i = 0; i < NR; i++) req_q[i].delete();
        @(negedge clk);
        #1;
        checkOutput("E_grant",   32'(grant),     32'h0);
        checkOutput("E_ready",   32'(req_ready), 32'h0);
        checkOutput("E_tx_en",   32'(tx_en),     32'h0);
        checkOutput("E_tx_data", 32'(tx_data),   32'h0);
        checkOutput("E_timeout", 32'(timeout),   32'h0);
        stepDrive();
        rst = 1'b0;
        busy_len = 3;
        snap_tx = tx_cnt;
        waitCycles(30);
        checkOutput("E_no_tx_after", 32'(tx_cnt - snap_tx), 32'd0);

        // UART busy for a long time: no restart and no new acceptance.
        startTest();
        busy_len = 100;
        applyStimulus(0, 8'h60, 1'b1);
        applyStimulus(1, 8'h61, 1'b1);
        waitTx("F_first_tx", 1, 50);
        snap_tx    = tx_cnt;
        snap_ready = ready_cnt;
        waitCycles(90);
        checkOutput("F_no_tx",    32'(tx_cnt - snap_tx),       32'd0);
        checkOutput("F_no_ready", 32'(ready_cnt - snap_ready), 32'd0);
        checkOutput("F_gnt_held", 32'(grant), 32'h1);
        waitQuiet("F_done", 400);
        busy_len = 3;
        checkOutput("F_tx0_data", txData(0),  32'h60);
        checkOutput("F_tx1_data", txData(1),  32'h61);
        checkOutput("F_tx1_gnt",  txGrant(1), 32'h2);

        checkOutput("ready_onehot", 32'(multi_ready), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
